// File: rtl/msu_pkg.sv
// Shared state encoding and sector geometry for the MSU sector responder.
package msu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACKDLY,
        ST_FETCH,
        ST_WRITE,
        ST_DONE
    } msu_state_e;

    localparam int SECTOR_BYTES = 512;
    localparam int OFFSET_W     = 41;

endpackage

// File: rtl/msu_sd_word_fetch.sv
// Fetches one sector word: compares the byte offset against the image size,
// masks the odd-size tail byte and runs the backing-memory read handshake.
module msu_sd_word_fetch
    import msu_pkg::*;
#(
    parameter int WORDS_PER_SECTOR = 256,
    parameter int MEM_AW           = 24,
    localparam int WW              = (WORDS_PER_SECTOR > 1) ? $clog2(WORDS_PER_SECTOR) : 1
) (
    input  logic              start_i,
    input  logic [31:0]       lba_i,
    input  logic [WW-1:0]     w_i,
    input  logic [31:0]       size_i,
    output logic              done_o,
    output logic [15:0]       word_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic              mem_rd_o,
    input  logic              mem_ready_i,
    input  logic [15:0]       mem_dout_i
);

    logic [OFFSET_W-1:0] offset;
    logic [OFFSET_W-1:0] offset_end;
    logic [OFFSET_W-1:0] size_ext;
    logic                in_range;
    logic                tail;
    logic                need_mem;
    logic [MEM_AW-1:0]   word_addr;

    always_comb begin
        offset     = OFFSET_W'(lba_i) * OFFSET_W'(SECTOR_BYTES) + (OFFSET_W'(w_i) << 1);
        offset_end = offset + OFFSET_W'(1);
        size_ext   = OFFSET_W'(size_i);
        in_range   = offset_end < size_ext;
        tail       = offset_end == size_ext;
        need_mem   = in_range | tail;

        // Truncating casts give the LBA wrap for free: the address is taken modulo 2^MEM_AW.
        word_addr  = MEM_AW'(lba_i) * MEM_AW'(WORDS_PER_SECTOR) + MEM_AW'(w_i);

        mem_rd_o   = start_i & need_mem;
        mem_addr_o = mem_rd_o ? word_addr : '0;
        done_o     = start_i & (~need_mem | mem_ready_i);

        if (in_range) begin
            word_o = mem_dout_i;
        end else if (tail) begin
            word_o = {8'h00, mem_dout_i[7:0]};
        end else begin
            word_o = 16'h0000;
        end
    end

endmodule

// File: rtl/msu_sd_responder.sv
// Target side of the MSU sector-read handshake: serves 512-byte sectors of a
// mounted image from a word-wide backing memory, one write strobe per word.
module msu_sd_responder
    import msu_pkg::*;
#(
    parameter int WORDS_PER_SECTOR = 256,
    parameter int ACK_DELAY        = 4,
    parameter int MEM_AW           = 24
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              img_mounted,
    input  logic [31:0]       img_size,
    input  logic [31:0]       sd_lba,
    input  logic              sd_rd,
    output logic              sd_ack,
    output logic [7:0]        sd_buff_addr,
    output logic [15:0]       sd_buff_dout,
    output logic              sd_buff_wr,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_rd,
    input  logic              mem_ready,
    input  logic [15:0]       mem_dout,
    output logic [15:0]       sectors_served
);

    localparam int WW = (WORDS_PER_SECTOR > 1) ? $clog2(WORDS_PER_SECTOR) : 1;
    localparam int DW = (ACK_DELAY > 0) ? $clog2(ACK_DELAY + 1) : 1;
    localparam logic [WW-1:0] LAST_W = WW'(WORDS_PER_SECTOR - 1);

    msu_state_e    state_q, state_d;
    logic [31:0]   size_q, size_d;
    logic [31:0]   lba_q, lba_d;
    logic [WW-1:0] w_q, w_d;
    logic [DW-1:0] dly_q, dly_d;
    logic          ack_q, ack_d;
    logic [15:0]   word_q, word_d;
    logic [15:0]   served_q, served_d;

    logic          fetch_start;
    logic          fetch_done;
    logic [15:0]   fetch_word;

    assign fetch_start = (state_q == ST_FETCH);

    msu_sd_word_fetch #(
        .WORDS_PER_SECTOR (WORDS_PER_SECTOR),
        .MEM_AW           (MEM_AW)
    ) u_fetch (
        .start_i     (fetch_start),
        .lba_i       (lba_q),
        .w_i         (w_q),
        .size_i      (size_q),
        .done_o      (fetch_done),
        .word_o      (fetch_word),
        .mem_addr_o  (mem_addr),
        .mem_rd_o    (mem_rd),
        .mem_ready_i (mem_ready),
        .mem_dout_i  (mem_dout)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            size_q   <= '0;
            lba_q    <= '0;
            w_q      <= '0;
            dly_q    <= '0;
            ack_q    <= 1'b0;
            word_q   <= '0;
            served_q <= '0;
        end else begin
            state_q  <= state_d;
            size_q   <= size_d;
            lba_q    <= lba_d;
            w_q      <= w_d;
            dly_q    <= dly_d;
            ack_q    <= ack_d;
            word_q   <= word_d;
            served_q <= served_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        size_d   = size_q;
        lba_d    = lba_q;
        w_d      = w_q;
        dly_d    = dly_q;
        ack_d    = ack_q;
        word_d   = word_q;
        served_d = served_q;

        case (state_q)
            ST_IDLE: begin
                if (sd_rd && (size_q != 32'd0)) begin
                    lba_d   = sd_lba;
                    w_d     = '0;
                    dly_d   = DW'(ACK_DELAY);
                    state_d = ST_ACKDLY;
                end
            end
            ST_ACKDLY: begin
                if (dly_q == '0) begin
                    ack_d   = 1'b1;
                    state_d = ST_FETCH;
                end else begin
                    dly_d = dly_q - DW'(1);
                end
            end
            ST_FETCH: begin
                if (fetch_done) begin
                    word_d  = fetch_word;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (w_q == LAST_W) begin
                    ack_d    = 1'b0;
                    served_d = served_q + 16'd1;
                    state_d  = ST_DONE;
                end else begin
                    w_d     = w_q + WW'(1);
                    state_d = ST_FETCH;
                end
            end
            ST_DONE: begin
                // Hold here until the requester releases sd_rd so each sector needs a fresh request.
                if (!sd_rd) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (img_mounted) begin
            size_d   = img_size;
            state_d  = ST_IDLE;
            ack_d    = 1'b0;
            served_d = served_q;
        end
    end

    generate
        if (WW >= 8) begin : g_addr_wide
            assign sd_buff_addr = w_q[7:0];
        end else begin : g_addr_narrow
            assign sd_buff_addr = {{(8 - WW){1'b0}}, w_q};
        end
    endgenerate

    assign sd_ack         = ack_q;
    assign sd_buff_wr     = (state_q == ST_WRITE);
    assign sd_buff_dout   = word_q;
    assign sectors_served = served_q;

endmodule

// File: tb/tb_msu_sd_responder.sv
// Directed bench for msu_sd_responder: zero-wait and random-latency memory,
// odd-size tail, out-of-image sector, mount abort and asynchronous reset.
module tb_msu_sd_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        img_mounted;
    logic [31:0] img_size;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_ack;
    logic [7:0]  sd_buff_addr;
    logic [15:0] sd_buff_dout;
    logic        sd_buff_wr;
    logic [23:0] mem_addr;
    logic        mem_rd;
    logic        mem_ready;
    logic [15:0] mem_dout;
    logic [15:0] sectors_served;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    msu_sd_responder #(
        .WORDS_PER_SECTOR (256),
        .ACK_DELAY        (4),
        .MEM_AW           (24)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .img_mounted    (img_mounted),
        .img_size       (img_size),
        .sd_lba         (sd_lba),
        .sd_rd          (sd_rd),
        .sd_ack         (sd_ack),
        .sd_buff_addr   (sd_buff_addr),
        .sd_buff_dout   (sd_buff_dout),
        .sd_buff_wr     (sd_buff_wr),
        .mem_addr       (mem_addr),
        .mem_rd         (mem_rd),
        .mem_ready      (mem_ready),
        .mem_dout       (mem_dout),
        .sectors_served (sectors_served)
    );

    // Memory model: each word holds its own address; latency 0 or random 0..7.
    logic rand_lat = 1'b0;
    int   lat_cnt  = 0;
    int   lat_tgt  = 0;

    assign mem_ready = mem_rd && (lat_cnt >= lat_tgt);
    assign mem_dout  = mem_ready ? mem_addr[15:0] : 16'hBEEF;

    always @(posedge clk) begin
        if (mem_rd && !mem_ready) begin
            lat_cnt <= lat_cnt + 1;
        end else begin
            lat_cnt <= 0;
            lat_tgt <= rand_lat ? int'($urandom_range(0, 7)) : 0;
        end
    end

    // Monitor: sampled on the falling edge, away from DUT updates.
    int          cyc = 0;
    int          wr_cnt = 0;
    int          order_err = 0;
    int          consec_err = 0;
    int          noack_err = 0;
    int          ack_rise_cyc = 0;
    int          ack_rise_cnt = 0;
    int          ack_fall_cyc = 0;
    int          last_wr_cyc = 0;
    int          rd_cyc_cnt = 0;
    int          hi_rd_cnt = 0;
    logic        prev_wr = 1'b0;
    logic        prev_ack = 1'b0;
    logic [7:0]  exp_addr = 8'd0;
    logic [15:0] cap [256];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        prev_wr  <= sd_buff_wr;
        prev_ack <= sd_ack;
        if (sd_ack && !prev_ack) begin
            ack_rise_cyc <= cyc;
            ack_rise_cnt <= ack_rise_cnt + 1;
            exp_addr     <= 8'd0;
        end
        if (!sd_ack && prev_ack) begin
            ack_fall_cyc <= cyc;
        end
        if (sd_buff_wr) begin
            cap[sd_buff_addr] <= sd_buff_dout;
            wr_cnt            <= wr_cnt + 1;
            last_wr_cyc       <= cyc;
            exp_addr          <= sd_buff_addr + 8'd1;
            if (sd_buff_addr != exp_addr) order_err <= order_err + 1;
            if (prev_wr) consec_err <= consec_err + 1;
            if (!sd_ack) noack_err <= noack_err + 1;
        end
        if (mem_rd) begin
            rd_cyc_cnt <= rd_cyc_cnt + 1;
            if (sd_buff_addr >= 8'd245) hi_rd_cnt <= hi_rd_cnt + 1;
        end
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic mount(input logic [31:0] sz);
        @(negedge clk); #1;
        img_size    = sz;
        img_mounted = 1'b1;
        @(negedge clk); #1;
        img_mounted = 1'b0;
    endtask

    task automatic wait_ack(input logic lvl, input int budget, input string tag);
        int k;
        k = 0;
        @(negedge clk);
        while (sd_ack !== lvl && k < budget) begin
            @(negedge clk);
            k++;
        end
        #1;
        if (sd_ack !== lvl) check_vec(tag, {31'd0, sd_ack}, {31'd0, lvl});
    endtask

    int rd_at = 0;

    task automatic run_sector(input logic [31:0] lba);
        @(negedge clk); #1;
        sd_lba = lba;
        sd_rd  = 1'b1;
        rd_at  = cyc;
        wait_ack(1'b1, 64, "ack_rise_timeout");
        sd_rd = 1'b0;
        wait_ack(1'b0, 8000, "ack_fall_timeout");
    endtask

    // mode 0: lba1 full image, 1: lba1 with 1001-byte image, 2: beyond image, 3: lba0.
    task automatic check_sector(input string tag, input int base, input int mode,
                                input logic [15:0] exp_served);
        logic [31:0] exp;
        check_vec({tag, "_strobes"}, 32'(wr_cnt - base), 32'd256);
        check_vec({tag, "_order"}, 32'(order_err), 32'd0);
        check_vec({tag, "_consec_wr"}, 32'(consec_err), 32'd0);
        check_vec({tag, "_wr_noack"}, 32'(noack_err), 32'd0);
        // Accept edge is one cycle after sd_rd rises; ack then follows 1+ACK_DELAY edges later.
        check_vec({tag, "_ack_lat"}, 32'(ack_rise_cyc - rd_at), 32'd6);
        check_vec({tag, "_ack_fall"}, 32'(ack_fall_cyc - last_wr_cyc), 32'd1);
        check_vec({tag, "_served"}, {16'd0, sectors_served}, {16'd0, exp_served});
        for (int i = 0; i < 256; i++) begin
            case (mode)
                0:       exp = 32'(256 + i);
                1:       exp = (i < 244) ? 32'(256 + i) : ((i == 244) ? 32'h00F4 : 32'd0);
                2:       exp = 32'd0;
                default: exp = 32'(i);
            endcase
            check_vec($sformatf("%s_w%0d", tag, i), {16'd0, cap[i]}, exp);
        end
        $display("sector %s lba=%0d strobes=%0d served=%0d", tag, sd_lba, wr_cnt - base, sectors_served);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int base2;
        int snap;
        int k;

        reset_n     = 1'b0;
        img_mounted = 1'b0;
        img_size    = 32'd0;
        sd_lba      = 32'd0;
        sd_rd       = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        check_vec("rst_ctl", {21'd0, sd_ack, sd_buff_wr, mem_rd, sd_buff_addr}, 32'd0);
        check_vec("rst_dout", {16'd0, sd_buff_dout}, 32'd0);
        check_vec("rst_served", {16'd0, sectors_served}, 32'd0);
        check_vec("rst_maddr", {8'd0, mem_addr}, 32'd0);
        reset_n = 1'b1;

        // Full image, zero-wait memory.
        mount(32'd1024);
        base = wr_cnt;
        run_sector(32'd1);
        check_sector("full", base, 0, 16'd1);

        // Odd-size image: tail byte masked, no reads past the end.
        mount(32'd1001);
        base  = wr_cnt;
        base2 = hi_rd_cnt;
        run_sector(32'd1);
        check_sector("tail", base, 1, 16'd2);
        check_vec("tail_no_rd_past_end", 32'(hi_rd_cnt - base2), 32'd0);

        // Sector entirely beyond the image.
        mount(32'd1024);
        base  = wr_cnt;
        base2 = rd_cyc_cnt;
        run_sector(32'd5);
        check_sector("beyond", base, 2, 16'd3);
        check_vec("beyond_no_mem_rd", 32'(rd_cyc_cnt - base2), 32'd0);

        // Random memory latency.
        rand_lat = 1'b1;
        base = wr_cnt;
        run_sector(32'd0);
        check_sector("randlat", base, 3, 16'd4);

        // Mount pulse at the 100th word aborts the sector.
        @(negedge clk); #1;
        sd_lba = 32'd1;
        sd_rd  = 1'b1;
        wait_ack(1'b1, 64, "abort_ack_timeout");
        sd_rd = 1'b0;
        base  = wr_cnt;
        k     = 0;
        while (wr_cnt < base + 100 && k < 4000) begin
            @(negedge clk); #1;
            k++;
        end
        img_size    = 32'd1024;
        img_mounted = 1'b1;
        @(negedge clk); #1;
        img_mounted = 1'b0;
        check_vec("abort_ack", {31'd0, sd_ack}, 32'd0);
        check_vec("abort_wr", {31'd0, sd_buff_wr}, 32'd0);
        check_vec("abort_mem_rd", {31'd0, mem_rd}, 32'd0);
        check_vec("abort_count", 32'(wr_cnt - base), 32'd100);
        repeat (20) @(negedge clk);
        #1;
        check_vec("abort_no_more_wr", 32'(wr_cnt - base), 32'd100);
        check_vec("abort_served", {16'd0, sectors_served}, 32'd4);
        $display("sector abort lba=1 strobes=%0d served=%0d", wr_cnt - base, sectors_served);

        base = wr_cnt;
        run_sector(32'd0);
        check_sector("post_abort", base, 3, 16'd5);

        // Asynchronous reset mid-sector.
        @(negedge clk); #1;
        sd_lba = 32'd0;
        sd_rd  = 1'b1;
        wait_ack(1'b1, 64, "rst_ack_timeout");
        sd_rd = 1'b0;
        base  = wr_cnt;
        k     = 0;
        while (wr_cnt < base + 50 && k < 4000) begin
            @(negedge clk); #1;
            k++;
        end
        #2;
        reset_n = 1'b0;
        #1;
        check_vec("arst_ctl", {21'd0, sd_ack, sd_buff_wr, mem_rd, sd_buff_addr}, 32'd0);
        check_vec("arst_dout", {16'd0, sd_buff_dout}, 32'd0);
        check_vec("arst_served", {16'd0, sectors_served}, 32'd0);
        check_vec("arst_maddr", {8'd0, mem_addr}, 32'd0);
        repeat (3) @(negedge clk);
        #1;
        reset_n = 1'b1;
        sd_rd   = 1'b1;
        snap    = ack_rise_cnt;
        base2   = rd_cyc_cnt;
        repeat (40) @(negedge clk);
        #1;
        check_vec("size0_no_ack", 32'(ack_rise_cnt - snap), 32'd0);
        check_vec("size0_ack_low", {31'd0, sd_ack}, 32'd0);
        check_vec("size0_no_mem_rd", 32'(rd_cyc_cnt - base2), 32'd0);
        sd_rd = 1'b0;
        $display("sector size0 request ignored, served=%0d", sectors_served);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
